// File: rtl/sram_uart_pkg.sv
// Shared register map, bit positions and LSR helper for the SRAM-mapped UART FIFO.
package sram_uart_pkg;

   // Register offsets within the 8-byte window (addra[2:0] / byte lane index)
   localparam logic [2:0] OffRbrThr = 3'd0;
   localparam logic [2:0] OffIer    = 3'd1;
   localparam logic [2:0] OffLsr    = 3'd5;
   localparam logic [2:0] OffScr    = 3'd7;

   // LSR bit positions
   localparam int unsigned LsrDr   = 0;
   localparam int unsigned LsrOe   = 1;
   localparam int unsigned LsrThre = 5;
   localparam int unsigned LsrTemt = 6;

   // IER bit positions
   localparam int unsigned IerRxEn   = 0;
   localparam int unsigned IerThreEn = 1;

   // LSR value out of reset: both FIFOs empty, output stage idle
   localparam logic [7:0] LsrResetVal = 8'h60;

   function automatic logic [7:0] build_lsr(input logic dr, input logic oe,
                                            input logic thre, input logic temt);
      logic [7:0] lsr;
      lsr          = '0;
      lsr[LsrDr]   = dr;
      lsr[LsrOe]   = oe;
      lsr[LsrThre] = thre;
      lsr[LsrTemt] = temt;
      return lsr;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: combinational head, push accepted on full only alongside a pop.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clka,
   input  logic                   rstn,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == FullCount);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // Pop on empty is ignored, so push+pop on empty just stores the byte
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Next-state for pointers (wrap naturally, depth is a power of 2) and occupancy
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PtrW + 1)'(1);
         2'b01:   count_d = count_q - (PtrW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers
   always_ff @(posedge clka) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array, deliberately not reset
   always_ff @(posedge clka) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/sram_uart_fifo.sv
// SRAM-style 64-bit register window fronting a byte TX/RX FIFO pair with a UART-like map.
module sram_uart_fifo
   import sram_uart_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR = 64'h60000000,
   parameter int unsigned TX_DEPTH  = 16,
   parameter int unsigned RX_DEPTH  = 16
) (
   input  logic        clka,
   input  logic        rstn,
   input  logic [63:0] addra,
   input  logic [63:0] dina,
   output logic [63:0] douta,
   input  logic        ena,
   input  logic [7:0]  wea,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_ready,
   output logic        irq
);

   logic [63:0] douta_q, douta_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic        irq_q, irq_d;
   logic [1:0]  ier_q, ier_d;
   logic [7:0]  scr_q, scr_d;
   logic        oe_q, oe_d;

   logic [2:0]  off;
   logic        rd_en, rbr_rd, lsr_rd, thr_wr;
   logic        tx_load, tx_empty, tx_full;
   logic [7:0]  tx_head;
   logic        rx_empty, rx_full, rx_pop_eff, oe_set;
   logic [7:0]  rx_head, rbr, lsr;
   logic [$clog2(TX_DEPTH):0] tx_count;
   logic [$clog2(RX_DEPTH):0] rx_count;

   assign off    = addra[2:0];
   assign rd_en  = ena & (wea == 8'h00);
   assign rbr_rd = rd_en & (off == OffRbrThr);
   assign lsr_rd = rd_en & (off == OffLsr);
   assign thr_wr = ena & wea[OffRbrThr];

   // Output stage refills whenever it is free or being drained this cycle
   assign tx_load    = (~tx_valid_q | tx_ready) & ~tx_empty;
   assign rx_pop_eff = rbr_rd & ~rx_empty;
   assign oe_set     = rx_ready & rx_full & ~rx_pop_eff;
   assign rbr        = rx_empty ? 8'h00 : rx_head;
   assign lsr        = build_lsr(~rx_empty, oe_q, tx_empty, tx_empty & ~tx_valid_q);

   sync_fifo #(
      .WIDTH(8),
      .DEPTH(TX_DEPTH)
   ) u_tx_fifo (
      .clka (clka),
      .rstn (rstn),
      .push (thr_wr),
      .pop  (tx_load),
      .din  (dina[7:0]),
      .dout (tx_head),
      .empty(tx_empty),
      .full (tx_full),
      .count(tx_count)
   );

   sync_fifo #(
      .WIDTH(8),
      .DEPTH(RX_DEPTH)
   ) u_rx_fifo (
      .clka (clka),
      .rstn (rstn),
      .push (rx_ready),
      .pop  (rbr_rd),
      .din  (rx_data),
      .dout (rx_head),
      .empty(rx_empty),
      .full (rx_full),
      .count(rx_count)
   );

   // Next-state for registers, output stage, read data and interrupt
   always_comb begin
      douta_d    = douta_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      ier_d      = ier_q;
      scr_d      = scr_q;
      oe_d       = oe_q;

      if (tx_load) begin
         tx_data_d  = tx_head;
         tx_valid_d = 1'b1;
      end else if (tx_ready) begin
         tx_valid_d = 1'b0;
      end

      if (ena & wea[OffIer]) ier_d = dina[8*OffIer +: 2];
      if (ena & wea[OffScr]) scr_d = dina[8*OffScr +: 8];

      // A new overrun in the same cycle as an LSR read must not be lost
      if (oe_set)      oe_d = 1'b1;
      else if (lsr_rd) oe_d = 1'b0;

      if (rd_en) begin
         douta_d                   = '0;
         douta_d[8*OffRbrThr +: 8] = rbr;
         douta_d[8*OffIer +: 8]    = {6'b0, ier_q};
         douta_d[8*OffLsr +: 8]    = lsr;
         douta_d[8*OffScr +: 8]    = scr_q;
      end

      irq_d = (ier_q[IerRxEn] & ~rx_empty) | (ier_q[IerThreEn] & tx_empty);
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clka) begin
      if (!rstn) begin
         douta_q    <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         irq_q      <= 1'b0;
         ier_q      <= '0;
         scr_q      <= '0;
         oe_q       <= 1'b0;
      end else begin
         douta_q    <= douta_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         irq_q      <= irq_d;
         ier_q      <= ier_d;
         scr_q      <= scr_d;
         oe_q       <= oe_d;
      end
   end

   assign douta    = douta_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign irq      = irq_q;

   // Address decode lives outside; high address bits, spare lanes and counts are not consumed
   logic unused_bits;
   assign unused_bits = ^{addra[63:3], dina[55:10], wea[6:2], BASE_ADDR, tx_full,
                          tx_count, rx_count, LsrResetVal};

endmodule

// File: tb/tb_sram_uart_fifo.sv
// Self-checking bench for sram_uart_fifo: directed scenarios plus randomized traffic vs a queue model.
module tb_sram_uart_fifo;

   localparam int TX_DEPTH = 16;
   localparam int RX_DEPTH = 16;
   localparam logic [63:0] ResetRead = 64'h0000_6000_0000_0000;

   logic        clka;
   logic        rstn;
   logic [63:0] addra;
   logic [63:0] dina;
   logic [63:0] douta;
   logic        ena;
   logic [7:0]  wea;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   logic [7:0]  m_txq[$];
   logic [7:0]  m_rxq[$];
   logic        m_txv;
   logic [7:0]  m_txd;
   logic [63:0] m_douta;
   logic        m_irq;
   logic [1:0]  m_ier;
   logic [7:0]  m_scr;
   logic        m_oe;

   sram_uart_fifo #(
      .BASE_ADDR(64'h60000000),
      .TX_DEPTH (TX_DEPTH),
      .RX_DEPTH (RX_DEPTH)
   ) dut (
      .clka    (clka),
      .rstn    (rstn),
      .addra   (addra),
      .dina    (dina),
      .douta   (douta),
      .ena     (ena),
      .wea     (wea),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .rx_data (rx_data),
      .rx_ready(rx_ready),
      .irq     (irq)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // One clock of the UART as seen from the register map, computed from current inputs
   task automatic model_step();
      logic       rd, load, thr_ok, rpop, irq_n;
      logic [7:0] lsr, rbr;
      if (!rstn) begin
         m_txq.delete();
         m_rxq.delete();
         m_txv = 0; m_txd = 0; m_douta = 0; m_irq = 0; m_ier = 0; m_scr = 0; m_oe = 0;
      end else begin
         rd  = ena && (wea == 8'h00);
         lsr = 8'h00;
         lsr[0] = m_rxq.size() != 0;
         lsr[1] = m_oe;
         lsr[5] = m_txq.size() == 0;
         lsr[6] = (m_txq.size() == 0) && !m_txv;
         rbr = (m_rxq.size() != 0) ? m_rxq[0] : 8'h00;
         irq_n = (m_ier[0] && m_rxq.size() != 0) || (m_ier[1] && m_txq.size() == 0);
         if (rd) m_douta = {m_scr, 8'h00, lsr, 24'h000000, 6'b0, m_ier, rbr};
         load   = (!m_txv || tx_ready) && m_txq.size() != 0;
         thr_ok = ena && wea[0] && (m_txq.size() < TX_DEPTH || load);
         if (load) begin
            m_txd = m_txq.pop_front();
            m_txv = 1;
         end else if (tx_ready) begin
            m_txv = 0;
         end
         if (thr_ok) m_txq.push_back(dina[7:0]);
         rpop = rd && addra[2:0] == 3'd0 && m_rxq.size() != 0;
         if (rx_ready && m_rxq.size() == RX_DEPTH && !rpop) m_oe = 1;
         else if (rd && addra[2:0] == 3'd5) m_oe = 0;
         if (rpop) void'(m_rxq.pop_front());
         if (rx_ready && m_rxq.size() < RX_DEPTH) m_rxq.push_back(rx_data);
         if (ena && wea[1]) m_ier = dina[9:8];
         if (ena && wea[7]) m_scr = dina[63:56];
         m_irq = irq_n;
      end
   endtask

   // Inputs are set at the negedge; advance model, cross the posedge, return at the negedge
   task automatic tick();
      model_step();
      @(posedge clka);
      @(negedge clka);
   endtask

   task automatic do_read(input logic [2:0] off);
      ena   = 1;
      wea   = 8'h00;
      addra = {$urandom(), $urandom()};
      addra[2:0] = off;
      tick();
      ena = 0;
   endtask

   task automatic do_write(input logic [7:0] lanes, input logic [63:0] data);
      ena   = 1;
      wea   = lanes;
      dina  = data;
      addra = {$urandom(), $urandom()};
      tick();
      ena = 0;
      wea = 8'h00;
   endtask

   task automatic test_reset();
      rstn = 0; ena = 0; wea = 0; addra = 0; dina = 0;
      tx_ready = 0; rx_ready = 0; rx_data = 0;
      @(negedge clka);
      tick();
      tick();
      rstn = 1;
      n_checks++;
      if (douta !== 64'h0) begin
         n_errors++; $display("FAIL reset_douta: got %h expected 0", douta);
      end
      n_checks++;
      if ({tx_valid, tx_data, irq} !== 10'h0) begin
         n_errors++; $display("FAIL reset_outputs: got v=%b d=%h irq=%b expected 0", tx_valid, tx_data, irq);
      end
      do_read(3'd5);
      n_checks++;
      if (douta !== ResetRead) begin
         n_errors++; $display("FAIL reset_regs: got %h expected %h", douta, ResetRead);
      end
   endtask

   task automatic test_regs();
      logic [7:0]  s, iv;
      logic [63:0] d, exp;
      for (int i = 0; i < 4; i++) begin
         s  = 8'($urandom());
         iv = 8'($urandom());
         d  = {$urandom(), $urandom()};
         d[63:56] = s;
         d[15:8]  = iv;
         // Lanes 1..7 in one write: only IER and SCR take effect
         do_write(8'hFE, d);
         do_read(3'($urandom_range(0, 7)));
         exp = {s, 8'h00, 8'h60, 24'h0, 6'b0, iv[1:0], 8'h00};
         n_checks++;
         if (douta !== exp) begin
            n_errors++; $display("FAIL regs_readback: got %h expected %h", douta, exp);
         end
         n_checks++;
         if (irq !== iv[1]) begin
            n_errors++; $display("FAIL regs_thre_irq: got %b expected %b", irq, iv[1]);
         end
         tick();
         n_checks++;
         if (douta !== exp) begin
            n_errors++; $display("FAIL regs_douta_hold: got %h expected %h", douta, exp);
         end
      end
      do_write(8'h82, 64'h0);
   endtask

   task automatic test_tx_basic();
      logic       ev[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [7:0] ed[5] = '{8'h00, 8'h41, 8'h42, 8'h43, 8'h00};
      tx_ready = 1;
      for (int i = 0; i < 5; i++) begin
         if (i < 3) do_write(8'h01, 64'(8'h41 + i));
         else tick();
         n_checks++;
         if (tx_valid !== ev[i] || (ev[i] && tx_data !== ed[i])) begin
            n_errors++;
            $display("FAIL tx_basic_%0d: got v=%b d=%h expected v=%b d=%h", i, tx_valid, tx_data, ev[i], ed[i]);
         end
      end
      do_read(3'd5);
      n_checks++;
      if (douta[47:40] !== 8'h60) begin
         n_errors++; $display("FAIL tx_basic_lsr: got %h expected 60", douta[47:40]);
      end
   endtask

   task automatic test_tx_overflow();
      logic [7:0] b[TX_DEPTH + 2];
      logic [7:0] got[$];
      tx_ready = 0;
      for (int i = 0; i < TX_DEPTH + 2; i++) begin
         b[i] = 8'($urandom());
         do_write(8'h01, {56'h0, b[i]});
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (tx_valid !== 1'b1 || tx_data !== b[0]) begin
            n_errors++; $display("FAIL tx_hold: got v=%b d=%h expected v=1 d=%h", tx_valid, tx_data, b[0]);
         end
      end
      do_read(3'd5);
      n_checks++;
      if (douta[47:40] !== 8'h00) begin
         n_errors++; $display("FAIL tx_full_lsr: got %h expected 00", douta[47:40]);
      end
      tx_ready = 1;
      for (int i = 0; i < 4 * TX_DEPTH; i++) begin
         if (tx_valid) got.push_back(tx_data);
         tick();
      end
      n_checks++;
      if (got.size() != TX_DEPTH + 1) begin
         n_errors++; $display("FAIL tx_drain_count: got %0d expected %0d", got.size(), TX_DEPTH + 1);
      end
      for (int i = 0; i < got.size() && i < TX_DEPTH + 1; i++) begin
         n_checks++;
         if (got[i] !== b[i]) begin
            n_errors++; $display("FAIL tx_drain_byte_%0d: got %h expected %h", i, got[i], b[i]);
         end
      end
   endtask

   task automatic test_rx_overrun();
      for (int i = 0; i <= RX_DEPTH; i++) begin
         rx_ready = 1;
         rx_data  = 8'(i);
         tick();
      end
      rx_ready = 0;
      do_read(3'd5);
      n_checks++;
      if (douta[47:40] !== 8'h63) begin
         n_errors++; $display("FAIL rx_overrun_lsr: got %h expected 63", douta[47:40]);
      end
      do_read(3'd5);
      n_checks++;
      if (douta[47:40] !== 8'h61) begin
         n_errors++; $display("FAIL rx_oe_clear: got %h expected 61", douta[47:40]);
      end
      for (int i = 0; i < RX_DEPTH; i++) begin
         do_read(3'd0);
         n_checks++;
         if (douta[7:0] !== 8'(i)) begin
            n_errors++; $display("FAIL rx_rbr_%0d: got %h expected %h", i, douta[7:0], 8'(i));
         end
      end
      do_read(3'd5);
      n_checks++;
      if (douta[47:40] !== 8'h60) begin
         n_errors++; $display("FAIL rx_drained_lsr: got %h expected 60", douta[47:40]);
      end
   endtask

   task automatic test_irq();
      do_write(8'h02, 64'h0100);
      rx_ready = 1;
      rx_data  = 8'h55;
      tick();
      rx_ready = 0;
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++; $display("FAIL irq_early: got %b expected 0", irq);
      end
      tick();
      n_checks++;
      if (irq !== 1'b1) begin
         n_errors++; $display("FAIL irq_rise: got %b expected 1", irq);
      end
      do_read(3'd0);
      n_checks++;
      if (douta[7:0] !== 8'h55 || irq !== 1'b1) begin
         n_errors++; $display("FAIL irq_rbr: got d=%h irq=%b expected d=55 irq=1", douta[7:0], irq);
      end
      tick();
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++; $display("FAIL irq_clear: got %b expected 0", irq);
      end
      do_write(8'h02, 64'h0);
   endtask

   task automatic test_rx_full_pushpop();
      logic [7:0] exp[$];
      logic [7:0] x;
      for (int i = 0; i < RX_DEPTH; i++) begin
         rx_ready = 1;
         rx_data  = 8'($urandom());
         exp.push_back(rx_data);
         tick();
      end
      x = 8'($urandom());
      rx_ready = 1;
      rx_data  = x;
      do_read(3'd0);
      rx_ready = 0;
      n_checks++;
      if (douta[7:0] !== exp[0]) begin
         n_errors++; $display("FAIL rx_full_pop: got %h expected %h", douta[7:0], exp[0]);
      end
      void'(exp.pop_front());
      exp.push_back(x);
      do_read(3'd5);
      n_checks++;
      if (douta[47:40] !== 8'h61) begin
         n_errors++; $display("FAIL rx_full_no_oe: got %h expected 61", douta[47:40]);
      end
      for (int i = 0; i < RX_DEPTH; i++) begin
         do_read(3'd0);
         n_checks++;
         if (douta[7:0] !== exp[i]) begin
            n_errors++; $display("FAIL rx_full_drain_%0d: got %h expected %h", i, douta[7:0], exp[i]);
         end
      end
      // Push and pop together on an empty FIFO: reads 0, keeps the byte
      x = 8'($urandom_range(1, 255));
      rx_ready = 1;
      rx_data  = x;
      do_read(3'd0);
      rx_ready = 0;
      n_checks++;
      if (douta[7:0] !== 8'h00) begin
         n_errors++; $display("FAIL rx_empty_pushpop: got %h expected 00", douta[7:0]);
      end
      do_read(3'd0);
      n_checks++;
      if (douta[7:0] !== x || douta[47:40] !== 8'h61) begin
         n_errors++; $display("FAIL rx_empty_kept: got %h lsr %h expected %h lsr 61", douta[7:0], douta[47:40], x);
      end
   endtask

   task automatic test_reset_mid();
      tx_ready = 0;
      do_write(8'h83, 64'hA500_0000_0000_0311);
      do_write(8'h01, 64'h22);
      for (int i = 0; i < 3; i++) begin
         rx_ready = 1;
         rx_data  = 8'($urandom());
         tick();
      end
      rx_ready = 0;
      tick();
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h11 || irq !== 1'b1) begin
         n_errors++; $display("FAIL mid_pre: got v=%b d=%h irq=%b expected v=1 d=11 irq=1", tx_valid, tx_data, irq);
      end
      rstn = 0;
      tick();
      rstn = 1;
      n_checks++;
      if ({tx_valid, tx_data, irq} !== 10'h0 || douta !== 64'h0) begin
         n_errors++; $display("FAIL mid_reset: got v=%b d=%h irq=%b douta=%h expected 0", tx_valid, tx_data, irq, douta);
      end
      do_read(3'd5);
      n_checks++;
      if (douta !== ResetRead) begin
         n_errors++; $display("FAIL mid_regs: got %h expected %h", douta, ResetRead);
      end
      tx_ready = 1;
      tick();
      tick();
      n_checks++;
      if (tx_valid !== 1'b0 || irq !== 1'b0) begin
         n_errors++; $display("FAIL mid_discard: got v=%b irq=%b expected 0 0", tx_valid, irq);
      end
   endtask

   task automatic test_random();
      logic [2:0] offs[6] = '{3'd0, 3'd0, 3'd5, 3'd1, 3'd7, 3'd3};
      rstn = 0;
      tick();
      rstn = 1;
      for (int i = 0; i < 600; i++) begin
         ena   = 1'($urandom_range(0, 1));
         wea   = ($urandom_range(0, 9) < 6) ? 8'h00 : 8'($urandom());
         addra = {$urandom(), $urandom()};
         addra[2:0] = offs[$urandom_range(0, 5)];
         dina     = {$urandom(), $urandom()};
         tx_ready = $urandom_range(0, 3) != 0;
         rx_ready = $urandom_range(0, 2) == 0;
         rx_data  = 8'($urandom());
         tick();
         n_checks++;
         if (douta !== m_douta) begin
            n_errors++; $display("FAIL rand_douta @%0d: got %h expected %h", i, douta, m_douta);
         end
         n_checks++;
         if (tx_valid !== m_txv || tx_data !== m_txd) begin
            n_errors++; $display("FAIL rand_tx @%0d: got v=%b d=%h expected v=%b d=%h", i, tx_valid, tx_data, m_txv, m_txd);
         end
         n_checks++;
         if (irq !== m_irq) begin
            n_errors++; $display("FAIL rand_irq @%0d: got %b expected %b", i, irq, m_irq);
         end
      end
      ena = 0; wea = 0; rx_ready = 0;
   endtask

   initial begin
      test_reset();
      test_regs();
      test_tx_basic();
      test_tx_overflow();
      test_rx_overrun();
      test_irq();
      test_rx_full_pushpop();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sram_uart_fifo.md
SRAM_UART_FIFO -- requirements
Module: sram_uart_fifo

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; clock port `clka`, reset port `rstn`.
REQ-002 Parameters SHALL be, one per line:
- `BASE_ADDR`, default 64'h60000000, base address (documentation only; decode is external).
- `TX_DEPTH`, default 16, TX FIFO entries; power of 2, at least 2.
- `RX_DEPTH`, default 16, RX FIFO entries; power of 2, at least 2.

REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- `clka`, in, 1, clock.
- `rstn`, in, 1, synchronous active-low reset.
- `addra`, in, 64, byte address; only [2:0] is used.
- `dina`, in, 64, write data; byte lane k = dina[8k+7:8k].
- `douta`, out, 64, registered read data; lane k = register at offset k.
- `ena`, in, 1, access strobe.
- `wea`, in, 8, per-lane write enables; all zero = read.
- `tx_data`, out, 8, byte to PHY.
- `tx_valid`, out, 1, tx_data valid.
- `tx_ready`, in, 1, PHY accepts.
- `rx_data`, in, 8, byte from PHY.
- `rx_ready`, in, 1, one-cycle strobe: rx_data valid.
- `irq`, out, 1, registered interrupt.

Function
REQ-004 The register map by offset SHALL be:
- 0: RBR on read, THR on write.
- 1: IER, bit0 = RX-data enable, bit1 = THR-empty enable, other bits read 0.
- 5: LSR, read-only.
- 7: SCR, 8-bit scratch.
- All other offsets: read 0, writes ignored.

REQ-005 A write cycle (ena=1, wea[k]=1) SHALL write lane k's register with dina lane k; multiple lanes in one cycle are all written.
REQ-006 A THR write SHALL push dina[7:0] into the TX FIFO; when the FIFO is full and no PHY pop occurs that cycle, the byte is dropped and no state changes.
REQ-007 A THR write into a full FIFO in the same cycle as a PHY pop SHALL be accepted.
REQ-008 A read cycle (ena=1, wea=0) SHALL update douta on the next edge with all eight lanes: RBR = RX head (0x00 if empty), IER, LSR, SCR, zeros elsewhere.
- douta holds its value when ena=0.

REQ-009 A read with addra[2:0]=0 SHALL pop the RX FIFO when non-empty; douta[7:0] returns the pre-pop head.
REQ-010 LSR bits SHALL be:
- bit0 DR = RX FIFO non-empty.
- bit1 OE = overrun flag.
- bit5 THRE = TX FIFO empty.
- bit6 TEMT = TX FIFO empty and tx_valid=0.
- All other bits 0.

REQ-011 OE SHALL set when rx_ready=1, the RX FIFO is full and no pop occurs that cycle; that byte is dropped. A read with addra[2:0]=5 clears OE; a simultaneous set wins.
REQ-012 rx_ready on a full RX FIFO with a same-cycle pop SHALL be accepted without setting OE.
REQ-013 A simultaneous push and pop on an empty RX FIFO SHALL return 0x00 in RBR, pop nothing, and store the pushed byte.
REQ-014 The TX output stage SHALL load tx_data/tx_valid from the TX FIFO head whenever (tx_valid=0 or tx_ready=1) and the FIFO is non-empty.
- Otherwise tx_valid drops to 0 after a completed transfer.
- This allows one byte per cycle back-to-back.

REQ-015 While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL hold stable.
REQ-016 irq SHALL be registered as (IER[0] & DR) | (IER[1] & THRE), taking effect one cycle after the state change.
REQ-017 FIFO pointers SHALL wrap modulo depth; occupancy SHALL use one extra bit so that full and empty are distinguished.

Reset
REQ-018 With rstn=0 at a clka edge, the following SHALL be 0: douta, tx_data, tx_valid, irq, IER, SCR, OE, and both FIFO pointers and counts.
REQ-019 FIFO storage SHALL NOT be reset.
REQ-020 Reset mid-transfer SHALL discard all queued bytes, including any byte held in the output stage.

Structure
REQ-021 Package `sram_uart_pkg` SHALL hold the register offsets (0, 1, 5, 7), the LSR and IER bit positions, and the LSR reset value.
REQ-022 One sub-module `sync_fifo` SHALL be provided:
- Parameters: WIDTH, DEPTH.
- Ports: push, pop, din, dout, empty, full, count.
- Instantiated twice, for TX and RX.

Verification
REQ-023 Write 0x41, 0x42, 0x43 to THR with tx_ready=1 -> tx_data 0x41, 0x42, 0x43 on consecutive cycles; LSR then reads 0x60.
REQ-024 tx_ready=0, write TX_DEPTH+2 bytes -> the first TX_DEPTH+1 are retained (FIFO plus output stage) and the last is dropped; releasing tx_ready emits exactly TX_DEPTH+1 bytes, in order.
REQ-025 Inject RX_DEPTH+1 rx_ready strobes (0x00..0x10) with no reads -> LSR = 0x63; the first LSR read clears OE; RBR reads return 0x00..0x0F, then DR=0.
REQ-026 IER=0x01, inject rx byte 0x55 -> irq=1 two cycles after the strobe; reading RBR returns 0x55 and irq clears the cycle after the pop.
REQ-027 Assert rstn=0 with a byte held (tx_ready=0) and RX holding 3 bytes -> after reset tx_valid=0, LSR=0x60, IER=SCR=0, irq=0.
REQ-028 RX full, with rx_ready and an RBR read in the same cycle -> the byte is accepted, OE stays 0, and count is unchanged.
